// File: rtl/rgb_pwm_capture.sv
// Purpose: measure per-channel high time and stuck lines of the RGB PWM pins over a fixed window.
// Latency: result registered 1 cycle after the last sampled cycle (+2 pin-to-sample with RGB_CAP_SYNC_EN).
// Backpressure: valid holds until ready; a close while unaccepted overwrites the result and sets sticky ovf.
module rgb_pwm_capture #(
    parameter int WINDOW = 256,
    localparam int CW = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          red,
    input  logic          grn,
    input  logic          blu,
    output logic [CW-1:0] duty_r,
    output logic [CW-1:0] duty_g,
    output logic [CW-1:0] duty_b,
    output logic [2:0]    stuck,
    output logic          valid,
    input  logic          ready,
    output logic          ovf
);

    localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);

    // channel order {b,g,r} everywhere below
    logic [2:0]          pins;
    logic [2:0]          s;
    logic [WW-1:0]       win_cnt;
    logic [2:0][CW-1:0]  hi;
    logic [2:0][CW-1:0]  duty;
    logic [2:0]          edge_f;
    logic [2:0]          prev;
    logic                armed;   // a previous sample of this run exists to compare against
    logic [2:0]          chg;
    logic                close;
    logic                accept;

    assign pins = {blu, grn, red};

`ifdef RGB_CAP_SYNC_EN
    logic [2:0] sync1;
    logic [2:0] sync2;

    // two-flop synchronizer per line ahead of sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = pins;
`endif

    assign close  = en && (win_cnt == LAST);
    assign accept = valid && ready;
    // no comparison on the first sample after enable: prev is stale there
    assign chg    = armed ? (s ^ prev) : 3'b000;

    // window counter, per-channel high counters and edge flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            hi      <= '0;
            edge_f  <= '0;
            prev    <= '0;
            armed   <= 1'b0;
        end else if (!en) begin
            win_cnt <= '0;
            hi      <= '0;
            edge_f  <= '0;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            prev  <= s;
            if (close) begin
                win_cnt <= '0;
                hi      <= '0;
                edge_f  <= '0;
            end else begin
                win_cnt <= win_cnt + WW'(1);
                edge_f  <= edge_f | chg;
                for (int i = 0; i < 3; i++) begin
                    hi[i] <= hi[i] + CW'(s[i]);
                end
            end
        end
    end

    // result registers with valid/ready handshake and sticky overwrite flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty  <= '0;
            stuck <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else if (close) begin
            for (int i = 0; i < 3; i++) begin
                duty[i] <= hi[i] + CW'(s[i]);
            end
            stuck <= ~(edge_f | chg);
            valid <= 1'b1;
            if (valid && !ready) begin
                ovf <= 1'b1;
            end
        end else if (accept) begin
            valid <= 1'b0;
            ovf   <= 1'b0;
        end
    end

    assign duty_r = duty[0];
    assign duty_g = duty[1];
    assign duty_b = duty[2];

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Purpose: randomized + directed check of rgb_pwm_capture against a window-level reference model.
// Latency: model predicts each edge from inputs driven on the preceding falling edge.
// Backpressure: model predicts accepts and overwrites from its own pending-result view.
module tb_rgb_pwm_capture;

    localparam int WINDOW = 16;
    localparam int CW = $clog2(WINDOW + 1);
`ifdef RGB_CAP_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          red = 1'b0;
    logic          grn = 1'b0;
    logic          blu = 1'b0;
    logic          ready = 1'b0;
    logic [CW-1:0] duty_r;
    logic [CW-1:0] duty_g;
    logic [CW-1:0] duty_b;
    logic [2:0]    stuck;
    logic          valid;
    logic          ovf;

    int n_checks = 0;
    int n_fail = 0;
    int ph = 0;         // window position of the next sample driven

    typedef struct {
        int       d [3];
        bit [2:0] st;
        bit       ovf;
    } rec_t;

    rec_t exp_q[$];     // results the model expects to be accepted, in order
    bit   cur_valid;    // model view of valid/ovf for the current cycle
    bit   cur_ovf;

    rgb_pwm_capture #(.WINDOW(WINDOW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .red    (red),
        .grn    (grn),
        .blu    (blu),
        .duty_r (duty_r),
        .duty_g (duty_g),
        .duty_b (duty_b),
        .stuck  (stuck),
        .valid  (valid),
        .ready  (ready),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit r, input bit g, input bit b, input bit rdy);
        @(negedge clk);
        en = e; red = r; grn = g; blu = b; ready = rdy;
        ph = e ? (ph + 1) % WINDOW : 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst duty_r", duty_r, 0);
        chk("rst duty_g", duty_g, 0);
        chk("rst duty_b", duty_b, 0);
        chk("rst stuck", stuck, 0);
        chk("rst valid", valid, 0);
        chk("rst ovf", ovf, 0);
    endtask

    function automatic bit rnd_line(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return $urandom_range(0, 7) == 0;
        endcase
    endfunction

    // reference model: collects post-sync samples per window, evaluated once per edge
    initial begin : model
        bit [2:0] win[$];
        bit [2:0] last;
        bit [2:0] p1;
        bit [2:0] p2;
        bit [2:0] s;
        bit       cont;
        bit       pend;
        bit       ovf_m;
        bit       acc;
        bit       cls;
        rec_t     pend_rec;
        rec_t     nr;
        rec_t     r;
        cont = 0; pend = 0; ovf_m = 0; p1 = 0; p2 = 0; last = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                win.delete();
                cont = 0; pend = 0; ovf_m = 0; p1 = 0; p2 = 0;
                cur_valid = 0; cur_ovf = 0;
            end else begin
                cur_valid = pend;
                cur_ovf   = ovf_m;
                if (SYNC) begin
                    s  = p2;
                    p2 = p1;
                    p1 = {blu, grn, red};
                end else begin
                    s = {blu, grn, red};
                end
                acc = pend && ready;
                if (acc) begin
                    r = pend_rec;
                    r.ovf = ovf_m;
                    exp_q.push_back(r);
                end
                cls = 0;
                if (!en) begin
                    win.delete();
                    cont = 0;
                end else begin
                    win.push_back(s);
                    if (win.size() == WINDOW) begin
                        cls = 1;
                        for (int c = 0; c < 3; c++) begin
                            int  ones;
                            bit  ch;
                            ones = 0;
                            ch = cont && (win[0][c] != last[c]);
                            for (int i = 0; i < WINDOW; i++) begin
                                ones += int'(win[i][c]);
                                if (i > 0 && win[i][c] != win[i-1][c]) ch = 1;
                            end
                            nr.d[c] = ones;
                            nr.st[c] = !ch;
                        end
                        nr.ovf = 0;
                        last = win[WINDOW-1];
                        cont = 1;
                        win.delete();
                    end
                end
                if (cls) begin
                    if (pend && !ready) ovf_m = 1;
                    pend = 1;
                    pend_rec = nr;
                end else if (acc) begin
                    pend = 0;
                    ovf_m = 0;
                end
            end
        end
    end

    // monitor: per-cycle valid/ovf and result contents on every accept
    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            #2;
            chk("valid", valid, cur_valid);
            chk("ovf", ovf, cur_ovf);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected accept: got valid=1 expected no result at %0t", $time);
                end else begin
                    r = exp_q.pop_front();
                    chk("duty_r", duty_r, r.d[0]);
                    chk("duty_g", duty_g, r.d[1]);
                    chk("duty_b", duty_b, r.d[2]);
                    chk("stuck", stuck, r.st);
                    chk("acc ovf", ovf, r.ovf);
                end
            end else if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing accept: got valid=%0d ready=%0d expected accept at %0t", valid, ready, $time);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin : stim
        int m [3];
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) drive(0, 0, 0, 0, 0);
        drive(1, 1'($urandom_range(0, 1)), 1, 0, 1);
        rst_n = 1'b1;

        // warm-up with random lines, then reset mid-window
        repeat (40) drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
        #3 rst_n = 1'b0;
        ph = 0;
        #1 check_reset_outputs();
        repeat (2) drive(0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1);
        rst_n = 1'b1;
        while (ph != 0) drive(1, 0, 1, 0, 1);

        // red 25 %, green high, blue low
        repeat (3 * WINDOW) drive(1, ph < 4, 1, 0, 1);

        // three windows without ready, red 50 %, then a single accept
        repeat (3 * WINDOW) drive(1, ph < 8, 1, 0, 0);
        drive(1, ph < 8, 1, 0, 1);
        repeat (3) drive(1, ph < 8, 1, 0, 0);

        // accept coinciding with a window close
        while (ph != 0) drive(1, ph < 8, 0, 1, 0);
        for (int k = 0; k < 2 * WINDOW; k++) drive(1, ph < 5, 0, 1, k == 2 * WINDOW - 1);
        drive(1, ph < 5, 0, 1, 1);

        // enable dropped part-way through a window
        while (ph != 7) drive(1, 1'($urandom_range(0, 1)), 1, 0, 1);
        repeat (5) drive(0, 1'($urandom_range(0, 1)), 1, 0, 1);
        repeat (2 * WINDOW + 8) drive(1, 1'($urandom_range(0, 1)), 1, 0, 1);

        // single-cycle blue pulse on the last cycle of a window
        while (ph != WINDOW - 1) drive(1, 1, 0, 0, 1);
        drive(1, 1, 0, 1, 1);
        repeat (2 * WINDOW) drive(1, 1, 0, 0, 1);

        // randomized traffic
        for (int blk = 0; blk < 24; blk++) begin
            for (int c = 0; c < 3; c++) m[c] = $urandom_range(0, 3);
            repeat (64) drive($urandom_range(0, 99) != 0, rnd_line(m[0]), rnd_line(m[1]),
                              rnd_line(m[2]), $urandom_range(0, 3) != 0);
        end

        // drain
        repeat (40) drive(0, 0, 0, 0, 1);
        chk("queue drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
